lsu: RTL
========

# lsu

Load/store unit: the initiator that drives the byte-addressed, dual-read-port data RAM on behalf of the pipeline's memory stage. It accepts one load or store request at a time over a valid/ready handshake. It converts the request into RAM write-mode/address/data or a read address, waits out the RAM's registered read latency, and sign- or zero-extends load data. It returns a single response per request over a second valid/ready handshake.

## Interface
- No parameters; widths fixed at XLEN = 32.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid & req_ready at a rising edge.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  response present.
- resp_ready  in  1  response consumed when resp_valid & resp_ready at a rising edge.
- resp_rdata  out  32  extended load data; 0 for stores and faults.
- resp_fault  out  1  misaligned access (see Configuration).
- mem_addr  out  32  RAM read address (port 1).
- mem_rdata  in  32  RAM read data; registered in the RAM, valid the cycle after mem_addr is sampled.
- mem_write_mode  out  2  00 none, 01 byte, 10 half, 11 word.
- mem_write_addr  out  32  RAM write address.
- mem_write_data  out  32  RAM write data.

## Operation
- States: IDLE, ACCESS, WAIT, RESP. Reset state is IDLE.
- Reset values: resp_valid 0, resp_rdata 0, resp_fault 0, mem_write_mode 00, and the registered address and data at 0.
- req_ready = (state == IDLE).
- On acceptance, the unit registers addr, wdata, we, size and unsigned, then transitions IDLE → ACCESS.
- mem_addr and mem_write_addr are always driven from the registered address. mem_write_data is always driven from the registered wdata.
- mem_write_mode is combinational: it carries the size mapping only in ACCESS with we = 1, and is 00 otherwise.
  - Size mapping: byte → 01, half → 10, word and reserved → 11.
  - Result: exactly one write cycle per store.
- Store path: ACCESS → RESP. resp_rdata = 0 and resp_fault = 0.
- Load path: ACCESS → WAIT → RESP.
  - On the WAIT → RESP edge, resp_rdata captures extend(mem_rdata).
  - Byte: bits [7:0], extended from bit 7.
  - Half: bits [15:0], extended from bit 15.
  - Word and reserved: all 32 bits.
- RESP: resp_valid = 1, with resp_rdata and resp_fault held stable until the response is taken.
  - When resp_ready is high at an edge: go to IDLE and clear resp_valid.
  - While resp_ready stays low: remain in RESP.
- Requests are never accepted while a response is outstanding. There is one request in flight at most.
- Asynchronous reset mid-operation forces IDLE immediately and mem_write_mode to 00. A write is therefore aborted before its edge, and no response is produced for the in-flight request.

## Timing
- Store: accept at edge E0, RAM writes at E1, resp_valid is high in the cycle after E1.
- Load: accept at E0, RAM samples mem_addr at E1, the unit captures data at E2, resp_valid is high in the cycle after E2.
- Minimum issue interval: 3 cycles for a store and 4 for a load, each with resp_ready tied high.
- A store followed by a load to the same address returns the stored value, because the write edge precedes the load's read edge.
- mem_addr holds stable from ACCESS through RESP, so mem_rdata stays stable during WAIT.
- All outputs except mem_write_mode and req_ready are registered or driven from registers.

## Configuration
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - These accesses are misaligned: half with addr[0] = 1, word with addr[1:0] ≠ 00, and reserved size with addr[1:0] ≠ 00.
  - On accepting a misaligned request, the unit goes IDLE → RESP directly and performs no memory access (mem_write_mode stays 00).
  - The response is resp_fault = 1 and resp_rdata = 0.
- Undefined: all addresses pass through to the RAM, which assembles unaligned bytes little-endian, and resp_fault is tied 0.

## Test plan
- Store word 0xDEADBEEF to 0x100, then load word from 0x100 → one write cycle with mode 11, then resp_rdata 0xDEADBEEF.
- Store byte 0x80 to 0x104, then load byte signed and unsigned from 0x104 → 0xFFFFFF80 and 0x00000080.
- Store half 0x8001 to 0x108, then load half signed → 0xFFFF8001, with write mode 10 for exactly one cycle.
- Load with resp_ready held low for 5 cycles → resp_valid and resp_rdata stable throughout, req_ready 0 until the consume edge.
- Load word from 0x102: with LSU_MISALIGN_TRAP_EN, resp_fault = 1 after one cycle and no RAM write; without it, little-endian bytes 0x102..0x105 are returned.
- Assert rst during a store's ACCESS cycle → mem_write_mode drops to 00 immediately, memory is unchanged, and the unit is in IDLE with req_ready = 1 after release.

Source files
------------

// File: rtl/lsu.sv
// Load/store unit: one request at a time, drives a registered-read byte RAM and returns one response.
// Optional LSU_MISALIGN_TRAP_EN: misaligned half/word accesses skip the RAM and respond with resp_fault.
module lsu (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_fault,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_rdata,
   output logic [1:0]  mem_write_mode,
   output logic [31:0] mem_write_addr,
   output logic [31:0] mem_write_data
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_WAIT   = 2'd2,
      S_RESP   = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic        r_we;
   logic [1:0]  r_size;
   logic        r_unsigned;
   logic        r_resp_valid;
   logic [31:0] r_resp_rdata;
   logic        r_resp_fault;
   logic        w_accept;
   logic        w_misalign;
   logic [1:0]  w_write_mode;

   function automatic logic [31:0] extend(input logic [31:0] d, input logic [1:0] sz, input logic uns);
      case (sz)
         2'b00:   extend = {{24{~uns & d[7]}}, d[7:0]};
         2'b01:   extend = {{16{~uns & d[15]}}, d[15:0]};
         default: extend = d;
      endcase
   endfunction

   assign w_accept = req_valid && (r_state == S_IDLE);

`ifdef LSU_MISALIGN_TRAP_EN
   function automatic logic is_misaligned(input logic [1:0] sz, input logic [31:0] a);
      case (sz)
         2'b00:   is_misaligned = 1'b0;
         2'b01:   is_misaligned = a[0];
         default: is_misaligned = (a[1:0] != 2'b00);
      endcase
   endfunction

   assign w_misalign = w_accept && is_misaligned(req_size, req_addr);
`else
   assign w_misalign = 1'b0;
`endif

   // Next-state and write-strobe decode; the write mode exists only during a store's ACCESS cycle.
   always_comb begin
      w_next       = r_state;
      w_write_mode = 2'b00;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_next = w_misalign ? S_RESP : S_ACCESS;
            end else begin
               w_next = S_IDLE;
            end
         end
         S_ACCESS: begin
            if (r_we) begin
               w_next = S_RESP;
               case (r_size)
                  2'b00:   w_write_mode = 2'b01;
                  2'b01:   w_write_mode = 2'b10;
                  default: w_write_mode = 2'b11;
               endcase
            end else begin
               w_next = S_WAIT;
            end
         end
         S_WAIT: w_next = S_RESP;
         S_RESP: begin
            if (resp_ready) begin
               w_next = S_IDLE;
            end else begin
               w_next = S_RESP;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Request capture and response registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_addr       <= 32'd0;
         r_wdata      <= 32'd0;
         r_we         <= 1'b0;
         r_size       <= 2'b00;
         r_unsigned   <= 1'b0;
         r_resp_valid <= 1'b0;
         r_resp_rdata <= 32'd0;
         r_resp_fault <= 1'b0;
      end else begin
         if (w_accept) begin
            r_addr     <= req_addr;
            r_wdata    <= req_wdata;
            r_we       <= req_we;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
         end
         case (r_state)
            S_IDLE: begin
               if (w_misalign) begin
                  r_resp_valid <= 1'b1;
                  r_resp_rdata <= 32'd0;
                  r_resp_fault <= 1'b1;
               end
            end
            S_ACCESS: begin
               if (r_we) begin
                  r_resp_valid <= 1'b1;
                  r_resp_rdata <= 32'd0;
                  r_resp_fault <= 1'b0;
               end
            end
            // RAM data is valid here because mem_addr was sampled on the ACCESS edge.
            S_WAIT: begin
               r_resp_valid <= 1'b1;
               r_resp_rdata <= extend(mem_rdata, r_size, r_unsigned);
               r_resp_fault <= 1'b0;
            end
            S_RESP: begin
               if (resp_ready) begin
                  r_resp_valid <= 1'b0;
               end
            end
            default: r_resp_valid <= 1'b0;
         endcase
      end
   end

   assign req_ready      = (r_state == S_IDLE);
   assign resp_valid     = r_resp_valid;
   assign resp_rdata     = r_resp_rdata;
   assign resp_fault     = r_resp_fault;
   assign mem_addr       = r_addr;
   assign mem_write_addr = r_addr;
   assign mem_write_data = r_wdata;
   assign mem_write_mode = w_write_mode;

endmodule
